// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and the receive-side blocks:
// handshake state encodings, the default acknowledge timeout and the requester index type.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

  localparam int ACK_TMO_DEFAULT = 4096;

  // Wide enough to name any of up to 8 requesters.
  localparam int IDX_W = 3;
  typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
// Also used by the receive-side dispatcher.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         last,
  output logic             valid,
  output req_idx_t         winner
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = IDX_W + 1;

  logic [SW-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = last;
    idx    = '0;
    // Offsets 1..N_REQ put the last winner at the very end of the search.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = {1'b0, last} + SW'(i);
      if (idx >= SW'(N_REQ)) begin
        idx = idx - SW'(N_REQ);
      end
      if (!valid && req[idx[IW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte sources, one byte per round-robin grant,
// with a level handshake held until the UART (which samples only on its baud tick) responds.
//
//  state        | meaning
//  -------------+-------------------------------------------------------------
//  ST_IDLE      | waiting for an idle UART and any request
//  ST_ISSUE     | byte latched, din_rdy raised; timeout counter cleared
//  ST_WAIT_LOW  | holding din_rdy until uart_ready falls or the timeout expires
//  ST_WAIT_HIGH | UART sending the frame; waiting for uart_ready to return
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int ACK_TMO = ACK_TMO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_byte,
  output logic [N_REQ-1:0]        grant_ack,
  output logic                    din_rdy,
  output logic [DATA_W-1:0]       din_byte,
  input  logic                    uart_ready,
  output logic                    busy,
  output logic [IDX_W-1:0]        cur_grant,
  output logic                    err_tmo
);

  localparam int CW = $clog2(ACK_TMO);

  logic [1:0]        state;
  logic [CW-1:0]     tmo_cnt;
  logic [CW-1:0]     cnt_inc;
  logic              pick_valid;
  req_idx_t          pick_w;
  logic [DATA_W-1:0] sel_byte;
  logic [N_REQ-1:0]  sel_ack;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (req),
    .last   (cur_grant),
    .valid  (pick_valid),
    .winner (pick_w)
  );

  always_comb begin
    sel_byte = '0;
    sel_ack  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_w == IDX_W'(i)) begin
        sel_byte   = req_byte[i*DATA_W +: DATA_W];
        sel_ack[i] = 1'b1;
      end
    end
  end

  // Saturating so a stalled handshake can never wrap back under the limit.
  assign cnt_inc = (tmo_cnt == {CW{1'b1}}) ? tmo_cnt : tmo_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      din_rdy   <= 1'b0;
      din_byte  <= '0;
      grant_ack <= '0;
      busy      <= 1'b0;
      cur_grant <= IDX_W'(N_REQ - 1);
      err_tmo   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      grant_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (uart_ready && pick_valid) begin
            din_byte  <= sel_byte;
            cur_grant <= pick_w;
            grant_ack <= sel_ack;
            din_rdy   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          tmo_cnt <= cnt_inc;
          if (!uart_ready) begin
            din_rdy <= 1'b0;
            state   <= ST_WAIT_HIGH;
          end else if (cnt_inc == CW'(ACK_TMO - 1)) begin
            din_rdy <= 1'b0;
            err_tmo <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_WAIT_HIGH: begin
          if (uart_ready) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
